// File: rtl/mont_pkg.sv
// mont_pkg: shared constants and state encoding for the Montgomery reducer
package mont_pkg;
    localparam int WIDTH = 256;
    localparam int DIGIT = 64;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int AW    = 2 * WIDTH + 1;
    localparam int CW    = $clog2(NDIG);
    typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;
endpackage

// File: rtl/mont_digit_step.sv
// mont_digit_step: one word-serial Montgomery iteration, retiring the low digit of acc
module mont_digit_step
    import mont_pkg::*;
(
    input  logic [AW-1:0]    acc,
    input  logic [WIDTH-1:0] m,
    input  logic [DIGIT-1:0] m_inv,
    output logic [AW-1:0]    acc_next
);
    logic [DIGIT-1:0]       q;
    logic [WIDTH+DIGIT-1:0] qm;
    logic [AW-1:0]          sum;
    // q zeroes the low digit of acc + q*m, so the shift drops only zero bits
    always_comb begin
        q        = acc[DIGIT-1:0] * m_inv;
        qm       = q * m;
        sum      = acc + AW'(qm);
        acc_next = sum >> DIGIT;
    end
endmodule

// File: rtl/mont_reducer.sv
// mont_reducer: word-serial Montgomery reduction R = T*2^-WIDTH mod M; MONT_SKID_EN adds a 1-entry input buffer
module mont_reducer
    import mont_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] T,
    input  logic [WIDTH-1:0]   M,
    input  logic [DIGIT-1:0]   M_INV,
    output logic               in_ready,
    output logic [WIDTH-1:0]   R,
    output logic               out_valid,
    output logic               overflow
);
    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      acc, acc_next;
    logic [WIDTH-1:0]   m_r;
    logic [DIGIT-1:0]   mi_r;
    logic               free, start, drop;
    logic [2*WIDTH-1:0] ld_t;
    logic [WIDTH-1:0]   ld_m;
    logic [DIGIT-1:0]   ld_mi;

    mont_digit_step u_step (.acc(acc), .m(m_r), .m_inv(mi_r), .acc_next(acc_next));

`ifdef MONT_SKID_EN
    logic               buf_v;
    logic [2*WIDTH-1:0] buf_t;
    logic [WIDTH-1:0]   buf_m;
    logic [DIGIT-1:0]   buf_mi;
    // buffered entry launches ahead of live input; drop only when the buffer is full and we are busy
    always_comb begin
        in_ready = free | ~buf_v;
        start    = free & (buf_v | in_valid);
        ld_t     = buf_v ? buf_t : T;
        ld_m     = buf_v ? buf_m : M;
        ld_mi    = buf_v ? buf_mi : M_INV;
        drop     = in_valid & ~free & buf_v;
    end
    // fill when busy and empty, or refill the slot freed by a launch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_v  <= 1'b0;
            buf_t  <= '0;
            buf_m  <= '0;
            buf_mi <= '0;
        end else if (in_valid & (free ? buf_v : ~buf_v)) begin
            buf_v  <= 1'b1;
            buf_t  <= T;
            buf_m  <= M;
            buf_mi <= M_INV;
        end else if (free) begin
            buf_v  <= 1'b0;
        end
    end
`else
    // no buffering: accept only when idle or finishing, otherwise discard
    always_comb begin
        in_ready = free;
        start    = in_valid & free;
        ld_t     = T;
        ld_m     = M;
        ld_mi    = M_INV;
        drop     = in_valid & ~free;
    end
`endif

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ITER : IDLE;
            ITER:    state_nx = (cnt == CW'(NDIG - 1)) ? FINAL : ITER;
            FINAL:   state_nx = start ? ITER : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM output: block can take a new operand this cycle
    always_comb free = (state == IDLE) || (state == FINAL);

    // datapath: load on launch, iterate digits, final conditional subtract
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            m_r       <= '0;
            mi_r      <= '0;
            cnt       <= '0;
            R         <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start) begin
                acc  <= {1'b0, ld_t};
                m_r  <= ld_m;
                mi_r <= ld_mi;
                cnt  <= '0;
            end else if (state == ITER) begin
                acc  <= acc_next;
                cnt  <= cnt + 1'b1;
            end
            if (state == FINAL) begin
                R         <= (acc >= AW'(m_r)) ? WIDTH'(acc - AW'(m_r)) : acc[WIDTH-1:0];
                out_valid <= 1'b1;
            end
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mont_reducer.sv
// tb_mont_reducer: scoreboard bench for mont_reducer with a cycle model of acceptance and a radix-2 golden reducer
module tb_mont_reducer;
    logic         clock = 0;
    logic         reset_n = 0;
    logic         in_valid = 0;
    logic [511:0] T = '0;
    logic [255:0] M = '0;
    logic [63:0]  M_INV = '0;
    logic         in_ready;
    logic [255:0] R;
    logic         out_valid;
    logic         overflow;

    mont_reducer dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .T(T), .M(M), .M_INV(M_INV),
        .in_ready(in_ready), .R(R), .out_valid(out_valid), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {logic [255:0] r; int cyc;} exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int ph = 0;
    bit ov_exp = 0;
    bit bv = 0;
    logic [511:0] b_t;
    logic [255:0] b_m;
    logic [255:0] p25519;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [255:0] golden(input logic [511:0] t, input logic [255:0] m);
        logic [513:0] x;
        x = {2'b0, t};
        for (int i = 0; i < 256; i++) begin
            if (x[0]) x = x + {258'b0, m};
            x = x >> 1;
        end
        x = x % {258'b0, m};
        return x[255:0];
    endfunction

    function automatic logic [63:0] minv(input logic [255:0] m);
        logic [63:0] inv, m64;
        m64 = m[63:0];
        inv = 64'd1;
        for (int i = 0; i < 6; i++) inv = inv * (64'd2 - m64 * inv);
        return -inv;
    endfunction

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) check("spurious_out_valid", 256'd1, 256'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("R", R, e.r);
                check("latency", 256'(cyc - e.cyc), 256'd5);
            end
        end
    end

    task automatic step(input logic v, input logic [511:0] t, input logic [255:0] m);
        bit free, rdy, launch, drop;
        logic [511:0] lt;
        logic [255:0] lm;
        exp_t e;
        @(negedge clock);
        in_valid = v;
        T = t;
        M = m;
        M_INV = minv(m);
        free = (ph == 0) || (ph == 5);
`ifdef MONT_SKID_EN
        rdy = free | ~bv;
        launch = free & (bv | v);
        lt = bv ? b_t : t;
        lm = bv ? b_m : m;
        drop = v & ~free & bv;
        if (free & bv) begin
            if (v) begin b_t = t; b_m = m; end
            else bv = 0;
        end else if (~free & v & ~bv) begin
            bv = 1; b_t = t; b_m = m;
        end
`else
        rdy = free;
        launch = free & v;
        lt = t;
        lm = m;
        drop = v & ~free;
`endif
        check("in_ready", 256'(in_ready), 256'(rdy));
        check("overflow", 256'(overflow), 256'(ov_exp));
        if (launch) begin
            e.r = golden(lt, lm);
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        if (drop) ov_exp = 1;
        ph = launch ? 1 : free ? 0 : (ph == 4) ? 5 : ph + 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (sb.size() > 0 || bv); i++) step(0, '0, p25519);
        step(0, '0, p25519);
        check("drain", 256'(sb.size()), 256'd0);
    endtask

    function automatic logic [511:0] rand_t(input logic [255:0] m);
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        return t % {m, 256'b0};
    endfunction

    initial begin
        logic [255:0] rm;
        p25519 = {1'b0, {250{1'b1}}, 5'b01101};
        repeat (3) @(negedge clock);
        check("reset_R", R, '0);
        check("reset_out_valid", 256'(out_valid), '0);
        check("reset_overflow", 256'(overflow), '0);
        reset_n = 1;
        step(1, '0, p25519);
        drain();
        step(1, 512'(1) << 256, p25519);
        drain();
        step(1, {p25519 - 256'd1, 256'b0}, p25519);
        drain();
        step(1, {256'b0, p25519}, p25519);
        drain();
        for (int i = 0; i < 12; i++) step(1, rand_t(p25519), p25519);
        drain();
        check("overflow_after_burst", 256'(overflow), 256'(ov_exp));
        step(1, rand_t(p25519), p25519);
        step(0, '0, p25519);
        step(0, '0, p25519);
        @(negedge clock);
        in_valid = 0;
        reset_n = 0;
        #1;
        check("midop_reset_R", R, '0);
        check("midop_reset_out_valid", 256'(out_valid), '0);
        check("midop_reset_overflow", 256'(overflow), '0);
        sb.delete();
        ph = 0;
        ov_exp = 0;
        bv = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 10; i++) step(0, '0, p25519);
        step(1, rand_t(p25519), p25519);
        drain();
        for (int i = 0; i < 50000; i++) begin
            if (i % 5 == 0) begin
                for (int j = 0; j < 8; j++) rm[j*32 +: 32] = $urandom;
                rm[0] = 1'b1;
                if (rm == 256'd1) rm = p25519;
            end
            step(1, rand_t(rm), rm);
        end
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
